// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory sequencer: lane count, lane index, FSM states.
package lsu_pkg;
  localparam int NUM_LANES = 8;
  localparam int LANE_W    = 3;

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } lsu_seq_state_t;
endpackage

// File: rtl/lsu_lane_select.sv
// Lowest-set-bit priority encoder over the pending-lane mask.
module lsu_lane_select
  import lsu_pkg::*;
(
  input  logic [NUM_LANES-1:0] mask,
  output lane_idx_t            idx,
  output logic                 any_set
);

  // Scanning high-to-low lets the lowest set bit win.
  always_comb begin
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (mask[i]) idx = lane_idx_t'(i);
  end

  assign any_set = |mask;

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Serializes a warp-wide load/store onto a single-port memory, merging loads
// to identical addresses and gathering read data into a per-lane buffer.
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [NUM_LANES-1:0]                 req_mask,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic                                 mem_valid,
  input  logic                                 mem_ready,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic                                 mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [NUM_LANES-1:0]                 resp_mask,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] resp_rdata
);

  lsu_seq_state_t                       state;
  logic                                 we_r;
  logic [NUM_LANES-1:0]                 mask_r;
  logic [NUM_LANES-1:0]                 pending;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr_r;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata_r;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rdata_r;
  lane_idx_t                            lane;
  lane_idx_t                            lane_r;
  logic                                 lane_any;
  logic [NUM_LANES-1:0]                 lane_oh;
  logic [NUM_LANES-1:0]                 hit;
  logic [NUM_LANES-1:0]                 pending_st;
  logic [NUM_LANES-1:0]                 pending_ld;

  lsu_lane_select u_sel (
    .mask    (pending),
    .idx     (lane),
    .any_set (lane_any)
  );

  assign lane_oh = NUM_LANES'(1) << lane;

  // Every still-pending lane sharing the in-flight address takes the same read data.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_LANES; k++)
      hit[k] = pending[k] && (addr_r[k] == addr_r[lane_r]);
  end

  assign pending_st = pending & ~lane_oh;
  assign pending_ld = pending & ~hit;

  // Outputs decode registered state only; nothing combinational from req_valid.
  assign req_ready  = (state == IDLE);
  assign mem_valid  = (state == ISSUE) && lane_any;
  assign mem_we     = mem_valid && we_r;
  assign mem_addr   = mem_valid ? addr_r[lane] : '0;
  assign mem_wdata  = mem_we ? wdata_r[lane] : '0;
  assign resp_valid = (state == DONE);
  assign resp_mask  = mask_r;
  assign resp_rdata = rdata_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we_r    <= 1'b0;
      mask_r  <= '0;
      pending <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      lane_r  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_r    <= req_we;
            mask_r  <= req_mask;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            pending <= req_mask;
            rdata_r <= '0;
            state   <= (req_mask == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (mem_valid && mem_ready) begin
            if (we_r) begin
              pending <= pending_st;
              state   <= (pending_st == '0) ? DONE : ISSUE;
            end else begin
              lane_r <= lane;
              state  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            for (int k = 0; k < NUM_LANES; k++)
              if (hit[k]) rdata_r[k] <= mem_rdata;
            pending <= pending_ld;
            state   <= (pending_ld == '0) ? DONE : ISSUE;
          end
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Scoreboard bench: a sequential reference model predicts memory commands and
// responses; a memory responder and a monitor run alongside the stimulus.
module tb_lsu_mem_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              req_valid, req_ready, req_we;
  logic [7:0]        req_mask;
  logic [7:0][7:0]   req_addr;
  logic [7:0][15:0]  req_wdata;
  logic              mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [7:0]        mem_addr;
  logic [15:0]       mem_wdata, mem_rdata;
  logic              resp_valid, resp_ready;
  logic [7:0]        resp_mask;
  logic [7:0][15:0]  resp_rdata;

  lsu_mem_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_mask(resp_mask), .resp_rdata(resp_rdata)
  );

  int total = 0;
  int bad   = 0;

  logic [24:0]  exp_cmd[$];
  logic [135:0] exp_resp[$];
  logic [15:0]  rmem[256];
  logic [15:0]  dmem[256];

  // responder knobs
  int lat       = 1;
  int rdy_pct   = 100;
  int hold_knob = 0;
  bit spur      = 1'b0;

  // responder state
  bit          rd_pend;
  int          rd_cnt;
  int          hold_cnt;
  logic [15:0] rd_data;

  // monitor state
  bit           rd_out;
  bit           pv_mv, pv_mr, pv_rv, pv_rr;
  logic [24:0]  pv_cmd;
  logic [135:0] pv_resp;
  logic [24:0]  e_cmd;
  logic [135:0] e_resp;

  task automatic chk(input bit ok, input string name, input logic [135:0] act,
                     input logic [135:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Sequential semantics: lanes in ascending order, loads merged by first
  // occurrence of each address, last store to an address wins.
  task automatic model(input logic we, input logic [7:0] m, input logic [7:0][7:0] a,
                       input logic [7:0][15:0] w, output int exp_lat);
    logic [7:0]       seen[$];
    logic [7:0][15:0] rd;
    int               n;
    bit               found;
    rd = '0;
    n  = 0;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        if (we) begin
          exp_cmd.push_back({1'b1, a[k], w[k]});
          rmem[a[k]] = w[k];
          n++;
        end else begin
          rd[k] = rmem[a[k]];
          found = 1'b0;
          foreach (seen[j]) if (seen[j] == a[k]) found = 1'b1;
          if (!found) begin
            seen.push_back(a[k]);
            exp_cmd.push_back({1'b0, a[k], 16'h0});
          end
        end
      end
    end
    exp_lat = we ? n + 1 : 2 * seen.size() + 1;
    exp_resp.push_back({m, rd});
  endtask

  task automatic do_req(input logic we, input logic [7:0] m, input logic [7:0][7:0] a,
                        input logic [7:0][15:0] w, input bit chk_lat, input int stall);
    int exp_lat;
    int t;
    int n;
    model(we, m, a, w, exp_lat);
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(req_ready, "req_ready_wait", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_mask = m; req_addr = a; req_wdata = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!resp_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(resp_valid, "resp_timeout", resp_valid, 1);
    if (chk_lat) chk(n == exp_lat, "resp_latency", n, exp_lat);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk(!req_ready && resp_valid, "done_hold", {req_ready, resp_valid}, 2'b01);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // Memory model: reads return dmem after 'lat' cycles, ready throttled by knobs.
  initial begin : responder
    for (int i = 0; i < 256; i++) dmem[i] = 16'(i) + 16'h100;
    rd_pend = 1'b0; rd_cnt = 0; hold_cnt = 0; rd_data = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid && mem_ready) begin
        if (mem_we) dmem[mem_addr] = mem_wdata;
        else begin
          rd_pend = 1'b1;
          rd_cnt  = lat;
          rd_data = dmem[mem_addr];
        end
        hold_cnt = hold_knob;
      end else if (mem_valid && hold_cnt > 0) hold_cnt--;
      else if (!mem_valid) hold_cnt = hold_knob;
      @(posedge clk); #1;
      mem_ready  = (hold_cnt == 0) && (int'($urandom_range(0, 99)) < rdy_pct);
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_data;
          rd_pend    = 1'b0;
        end
      end else if (spur && $urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
    end
  end

  initial begin : monitor
    rd_out = 1'b0;
    pv_mv = 1'b0; pv_mr = 1'b0; pv_rv = 1'b0; pv_rr = 1'b0;
    pv_cmd = '0; pv_resp = '0;
    forever begin
      @(negedge clk);
      if (reset) rd_out = 1'b0;
      else begin
        if (pv_mv && !pv_mr)
          chk(mem_valid && ({mem_we, mem_addr, mem_wdata} == pv_cmd), "mem_cmd_stable",
              {mem_valid, mem_we, mem_addr, mem_wdata}, {1'b1, pv_cmd});
        if (pv_rv && !pv_rr)
          chk(resp_valid && ({resp_mask, resp_rdata} == pv_resp), "resp_stable",
              {resp_mask, resp_rdata}, pv_resp);
        if (mem_valid) chk(!rd_out, "one_outstanding", rd_out, 0);
        if (mem_rvalid) rd_out = 1'b0;
        if (mem_valid && mem_ready) begin
          if (!mem_we) rd_out = 1'b1;
          chk(exp_cmd.size() != 0, "cmd_expected", {mem_we, mem_addr, mem_wdata}, 0);
          if (exp_cmd.size() != 0) begin
            e_cmd = exp_cmd.pop_front();
            chk({mem_we, mem_addr, mem_wdata} == e_cmd, "mem_cmd",
                {mem_we, mem_addr, mem_wdata}, e_cmd);
          end
        end
        if (resp_valid && resp_ready) begin
          chk(exp_resp.size() != 0, "resp_expected", {resp_mask, resp_rdata}, 0);
          if (exp_resp.size() != 0) begin
            e_resp = exp_resp.pop_front();
            chk({resp_mask, resp_rdata} == e_resp, "resp_data", {resp_mask, resp_rdata}, e_resp);
          end
        end
      end
      pv_mv   = mem_valid && !reset;
      pv_mr   = mem_ready;
      pv_cmd  = {mem_we, mem_addr, mem_wdata};
      pv_rv   = resp_valid && !reset;
      pv_rr   = resp_ready;
      pv_resp = {resp_mask, resp_rdata};
    end
  end

  initial begin : stim
    logic [7:0][7:0]  a;
    logic [7:0][15:0] w;
    logic [7:0]       m;
    for (int i = 0; i < 256; i++) rmem[i] = 16'(i) + 16'h100;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mask = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(req_ready === 1'b1, "rst_req_ready", req_ready, 1);
    chk({mem_valid, mem_we, mem_addr, mem_wdata} === 26'h0, "rst_mem",
        {mem_valid, mem_we, mem_addr, mem_wdata}, 0);
    chk({resp_valid, resp_mask} === 9'h0, "rst_resp", {resp_valid, resp_mask}, 0);
    chk(resp_rdata === '0, "rst_rdata", resp_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 8 distinct loads in lane order
    for (int k = 0; k < 8; k++) begin a[k] = 8'(k); w[k] = 16'($urandom); end
    do_req(1'b0, 8'hFF, a, w, 1'b1, 0);
    // all lanes one address
    for (int k = 0; k < 8; k++) a[k] = 8'h20;
    do_req(1'b0, 8'hFF, a, w, 1'b1, 0);
    // duplicate-address stores, then read back the surviving value
    for (int k = 0; k < 8; k++) begin a[k] = 8'($urandom_range(64, 127)); w[k] = 16'($urandom); end
    a[0] = 8'h10; a[2] = 8'h10; w[0] = 16'hAAAA; w[2] = 16'hBBBB;
    do_req(1'b1, 8'h05, a, w, 1'b1, 0);
    do_req(1'b0, 8'h01, a, w, 1'b1, 0);
    // empty mask with writeback stall
    do_req(1'b0, 8'h00, a, w, 1'b1, 3);

    // ready stalls, slow reads, spurious rvalid
    hold_knob = 4; lat = 3; spur = 1'b1;
    for (int k = 0; k < 8; k++) begin a[k] = 8'($urandom_range(0, 3)); w[k] = 16'($urandom); end
    do_req(1'b0, 8'hFF, a, w, 1'b0, 1);
    do_req(1'b1, 8'h93, a, w, 1'b0, 0);
    do_req(1'b0, 8'h6D, a, w, 1'b0, 0);

    // reset while a read is in flight; the reply arrives after reset
    hold_knob = 0; lat = 4; spur = 1'b0; rdy_pct = 100;
    @(negedge clk);
    exp_cmd.push_back({1'b0, 8'h30, 16'h0});
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_mask = 8'h01;
    for (int k = 0; k < 8; k++) req_addr[k] = 8'h30;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(req_ready && !resp_valid && !mem_valid, "post_rst_ctrl",
        {req_ready, resp_valid, mem_valid}, 3'b100);
    chk(resp_mask == 8'h0, "post_rst_mask", resp_mask, 0);
    chk(resp_rdata == '0, "post_rst_rdata", resp_rdata, 0);
    lat = 1;
    for (int k = 0; k < 8; k++) a[k] = 8'(k + 2);
    do_req(1'b0, 8'h0F, a, w, 1'b1, 0);

    // randomized traffic; first part in the nominal timing regime
    for (int i = 0; i < 40; i++) begin
      if (i == 15) begin rdy_pct = 60; spur = 1'b1; end
      if (i >= 15) begin
        lat = int'($urandom_range(1, 3));
        hold_knob = (i % 5 == 0) ? 2 : 0;
      end
      m = 8'($urandom);
      if (i % 10 == 3) m = 8'h00;
      if (i % 10 == 7) m = 8'hFF;
      for (int k = 0; k < 8; k++) begin
        a[k] = 8'($urandom_range(0, 7));
        w[k] = 16'($urandom);
      end
      do_req($urandom_range(0, 2) == 0, m, a, w, i < 15, int'($urandom_range(0, 2)));
    end

    repeat (5) @(negedge clk);
    chk(exp_cmd.size() == 0, "cmd_queue_drained", exp_cmd.size(), 0);
    chk(exp_resp.size() == 0, "resp_queue_drained", exp_resp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_sequencer.md
# lsu_mem_sequencer

Memory-side sequencer of the load/store unit: accepts one warp-wide request of 8 per-lane addresses, as produced by the AGU, plus store data and an active-lane mask. It serializes the active lanes onto the single-port data-memory interface and coalesces loads to identical addresses into one access. It gathers read data back into a per-lane buffer and returns it to register writeback with a valid/ready handshake.

## Interface
- DATA_WIDTH, 16, word width of memory data and lane data
- ADDR_WIDTH, 8, memory address width
- NUM_LANES, 8, lanes per warp (fixed 8 for this design; mask width)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  sequencer idle, can accept
- req_we  input  1  1 = store, 0 = load
- req_mask  input  NUM_LANES  active lanes
- req_addr  input  NUM_LANES x ADDR_WIDTH  per-lane address
- req_wdata  input  NUM_LANES x DATA_WIDTH  per-lane store data
- mem_valid  output  1  memory command valid
- mem_ready  input  1  memory accepts command
- mem_we  output  1  command is a write
- mem_addr  output  ADDR_WIDTH  command address
- mem_wdata  output  DATA_WIDTH  write data
- mem_rvalid  input  1  read data valid (in order, ≥1 cycle after read handshake)
- mem_rdata  input  DATA_WIDTH  read data
- resp_valid  output  1  transaction complete
- resp_ready  input  1  writeback accepts response
- resp_mask  output  NUM_LANES  captured request mask
- resp_rdata  output  NUM_LANES x DATA_WIDTH  per-lane load data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - capture we, mask, addr, wdata.
  - pending = req_mask; resp_rdata cleared to 0.
  - Next state is ISSUE, or DONE if req_mask==0.
- ISSUE: mem_valid=1 for lane L = lowest set bit of pending; mem_addr=addr[L], mem_we=we, mem_wdata=wdata[L] (0 for loads). Command held stable until mem_ready.
  - Store handshake: clear pending[L]; stay in ISSUE if pending≠0, else go to DONE. Stores are never merged: duplicate addresses produce multiple writes in ascending lane order (highest lane wins).
  - Load handshake: record L as the in-flight lane, go to WAIT.
- WAIT: mem_valid=0. On mem_rvalid:
  - write mem_rdata into resp_rdata[k] for every lane k with pending[k]=1 and addr[k]==addr[L]; clear those pending bits (coalescing).
  - Next state is ISSUE if pending≠0, else DONE.
- DONE: resp_valid=1, outputs stable until resp_ready; then IDLE.
- Inactive lanes and all lanes of a store report resp_rdata=0.
- mem_rvalid outside WAIT is ignored.
- Exactly one memory read is outstanding at a time.
- Reset mid-transaction:
  - next state IDLE; pending, buffers and mask cleared.
  - a late mem_rvalid is ignored.
  - no command is re-issued.

## Timing
- Reset values: state IDLE, req_ready=1, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_mask=0, resp_rdata all 0.
- Cycle 0 = request accept edge. The first mem_valid is in cycle 1 (registered state, no combinational path from req_valid to mem_valid).
- Stores, mem_ready=1: lanes issue cycles 1..N; resp_valid at cycle N+1 (N = popcount(mask)).
- Loads, mem_ready=1, read latency 1, D distinct addresses: issue at odd cycles, rvalid at even cycles; resp_valid at cycle 2D+1.
- Empty mask: resp_valid at cycle 1.
- A new request is accepted no earlier than the cycle after the resp handshake.
- mem_ready stalls extend ISSUE cycle-for-cycle; rvalid delay extends WAIT.

## Structure
- Package lsu_pkg:
  - state enum lsu_seq_state_t {IDLE, ISSUE, WAIT, DONE}
  - NUM_LANES constant
  - lane-index type (3 bits)
- Sub-module lsu_lane_select: combinational lowest-set-bit priority encoder. Input is the NUM_LANES mask; outputs are the index and any_set. One instance drives L.
- Address-compare/merge vector is inline in the sequencer.

## Test plan
- Load, mask 0xFF, addrs 0..7, mem returns addr+0x100, latency 1 → 8 reads in lane order; resp_rdata[i]=0x100+i; resp_valid at cycle 17.
- Load, mask 0xFF, all addrs 0x20 → one read only; all lanes get same data; resp_valid at cycle 3.
- Store, mask 0x05, addr[0]=addr[2]=0x10, wdata 0xAAAA/0xBBBB → two writes: 0xAAAA then 0xBBBB; resp_rdata all 0; resp_mask=0x05.
- mask 0x00 → no mem_valid; resp_valid at cycle 1; stall resp_ready 3 cycles → req_ready stays 0, outputs stable.
- mem_ready low 4 cycles during ISSUE and rvalid latency 3 → mem command held stable; spurious rvalid in ISSUE ignored; data correct.
- Assert reset while in WAIT, then pulse mem_rvalid → IDLE, req_ready=1, resp_valid=0, buffers 0; next request completes correctly.
